// File: rtl/mult_serial_collector.sv
// Collects the LSB-first serial product stream of a bit-serial multiplier into a parallel word.
// Optional sticky overrun flag is built only when COLLECT_OVERRUN_EN is defined.
module mult_serial_collector #(
  parameter int N   = 1024,
  parameter int M   = N,
  parameter int LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             o_in,
  input  logic             out_ready,
  output logic             busy,
  output logic             valid,
  output logic [N+M-1:0]   result,
  output logic             overrun,
  output logic [1:0]       dbg_state_o
);

  localparam int W  = N + M;
  // The skip phase reuses the bit counter, so it must also hold LAT-1 for tiny products.
  localparam int CW = ($clog2(W + 1) > 3) ? $clog2(W + 1) : 3;
  localparam logic [CW-1:0] SKIP_LAST = (LAT > 0) ? CW'(LAT - 1) : '0;
  localparam logic [CW-1:0] BIT_LAST  = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, HOLD} state_t;

  // Consumer handshake: a result transfers on the rising edge where valid && out_ready;
  // valid only rises in HOLD and drops the cycle after the transfer.
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    result_q;
  logic            busy_q;
  logic            valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b1;
            if (LAT > 0) begin
              state_q <= SKIP;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SKIP: begin
          if (cnt_q == SKIP_LAST) begin
            cnt_q   <= '0;
            state_q <= SHIFT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        SHIFT: begin
          result_q[cnt_q] <= o_in;
          if (cnt_q == BIT_LAST) begin
            state_q <= HOLD;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign valid       = valid_q;
  assign result      = result_q;
  assign dbg_state_o = state_q;

`ifdef COLLECT_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_q <= 1'b0;
    end else if (start && (state_q != IDLE)) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_mult_serial_collector.sv
// Bench for mult_serial_collector: three instances (8x8 LAT=1, 8x8 LAT=0, 1024x1024 LAT=1)
// fed from products computed arithmetically and streamed LSB first.
module tb_mult_serial_collector;
  localparam int WMAX = 2048;

`ifdef COLLECT_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [2:0]        start_v;
  logic [2:0]        o_in_v;
  logic [2:0]        out_ready_v;
  logic [2:0]        busy_v;
  logic [2:0]        valid_v;
  logic [2:0]        overrun_v;
  logic [1:0]        st_a, st_b, st_c;
  logic [15:0]       res_a, res_b;
  logic [WMAX-1:0]   res_c;
  logic [2:0]        ovr_exp;

  int checks = 0;
  int failures = 0;

  mult_serial_collector #(.N(8), .M(8), .LAT(1)) u_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .o_in(o_in_v[0]), .out_ready(out_ready_v[0]),
    .busy(busy_v[0]), .valid(valid_v[0]), .result(res_a), .overrun(overrun_v[0]),
    .dbg_state_o(st_a)
  );

  mult_serial_collector #(.N(8), .M(8), .LAT(0)) u_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .o_in(o_in_v[1]), .out_ready(out_ready_v[1]),
    .busy(busy_v[1]), .valid(valid_v[1]), .result(res_b), .overrun(overrun_v[1]),
    .dbg_state_o(st_b)
  );

  mult_serial_collector #(.N(1024), .M(1024), .LAT(1)) u_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .o_in(o_in_v[2]), .out_ready(out_ready_v[2]),
    .busy(busy_v[2]), .valid(valid_v[2]), .result(res_c), .overrun(overrun_v[2]),
    .dbg_state_o(st_c)
  );

  function automatic int width_of(input int sel);
    return (sel == 2) ? 2048 : 16;
  endfunction

  function automatic int lat_of(input int sel);
    return (sel == 1) ? 0 : 1;
  endfunction

  function automatic logic [WMAX-1:0] get_res(input int sel);
    case (sel)
      0:       return WMAX'(res_a);
      1:       return WMAX'(res_b);
      default: return res_c;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ovr(input int sel, input string tag);
    check(tag, 64'(overrun_v[sel]), OVR_EN ? 64'(ovr_exp[sel]) : 64'd0);
  endtask

  task automatic check_full_result(input int sel, input logic [WMAX-1:0] prod, input string tag);
    logic [WMAX-1:0] r;
    r = get_res(sel);
    for (int c = 0; c < (width_of(sel) + 63) / 64; c++)
      check($sformatf("%s_chunk%0d", tag, c), r[c*64 +: 64], prod[c*64 +: 64]);
  endtask

  // Streams prod LSB first so bit k is sampled on edge lat+1+k after the start edge.
  task automatic run_capture(input int sel, input logic [WMAX-1:0] prod, input int hold_wait,
                             input int extra_start_j, input int abort_j, input string tag);
    int w, lat;
    logic [WMAX-1:0] r;
    w   = width_of(sel);
    lat = lat_of(sel);
    @(negedge clk);
    start_v[sel]     = 1'b1;
    o_in_v[sel]      = 1'($urandom_range(0, 1));
    out_ready_v[sel] = 1'($urandom_range(0, 1));
    for (int j = 1; j <= lat + w; j++) begin
      @(negedge clk);
      if (sel != 2 || j <= 3) begin
        check($sformatf("%s_busy_c%0d", tag, j), 64'(busy_v[sel]), 64'd1);
        check($sformatf("%s_valid_c%0d", tag, j), 64'(valid_v[sel]), 64'd0);
      end
      if (j == abort_j) begin
        rst = 1'b0;
        ovr_exp = '0;
        #1;
        check($sformatf("%s_rst_busy", tag), 64'(busy_v[sel]), 64'd0);
        check($sformatf("%s_rst_valid", tag), 64'(valid_v[sel]), 64'd0);
        r = get_res(sel);
        check($sformatf("%s_rst_result", tag), r[63:0], 64'd0);
        check_ovr(sel, $sformatf("%s_rst_overrun", tag));
        start_v[sel]     = 1'b0;
        out_ready_v[sel] = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        return;
      end
      start_v[sel] = (j == extra_start_j);
      if (j == extra_start_j) ovr_exp[sel] = 1'b1;
      o_in_v[sel]      = (j > lat) ? prod[j-lat-1] : 1'($urandom_range(0, 1));
      out_ready_v[sel] = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    start_v[sel]     = 1'b0;
    out_ready_v[sel] = 1'b0;
    check($sformatf("%s_valid_rise", tag), 64'(valid_v[sel]), 64'd1);
    check($sformatf("%s_busy_drop", tag), 64'(busy_v[sel]), 64'd0);
    check_full_result(sel, prod, $sformatf("%s_result", tag));
    check_ovr(sel, $sformatf("%s_overrun", tag));
    for (int h = 0; h < hold_wait; h++) begin
      @(negedge clk);
      r = get_res(sel);
      check($sformatf("%s_hold_valid%0d", tag, h), 64'(valid_v[sel]), 64'd1);
      check($sformatf("%s_hold_result%0d", tag, h), r[63:0], prod[63:0]);
    end
    // Release together with a start that must be ignored.
    out_ready_v[sel] = 1'b1;
    start_v[sel]     = 1'b1;
    ovr_exp[sel]     = 1'b1;
    @(negedge clk);
    out_ready_v[sel] = 1'b0;
    start_v[sel]     = 1'b0;
    check($sformatf("%s_release_valid", tag), 64'(valid_v[sel]), 64'd0);
    check($sformatf("%s_release_busy", tag), 64'(busy_v[sel]), 64'd0);
    check_ovr(sel, $sformatf("%s_release_overrun", tag));
  endtask

  initial begin
    logic [WMAX-1:0] g, e, p;
    logic [7:0] a, b;
    rst         = 1'b0;
    start_v     = '0;
    o_in_v      = '0;
    out_ready_v = '0;
    ovr_exp     = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      p = get_res(s);
      check($sformatf("reset_busy%0d", s), 64'(busy_v[s]), 64'd0);
      check($sformatf("reset_valid%0d", s), 64'(valid_v[s]), 64'd0);
      check($sformatf("reset_result%0d", s), p[63:0], 64'd0);
      check($sformatf("reset_overrun%0d", s), 64'(overrun_v[s]), 64'd0);
    end
    @(posedge clk);
    #2 rst = 1'b1;

    run_capture(0, WMAX'(255 * 170), 5, -1, -1, "p255x170");
    run_capture(1, WMAX'(16'hFFFF), 2, -1, -1, "ones_lat0");

    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    run_capture(0, WMAX'(16'(a) * 16'(b)), 0, -1, 1 + 6, "abort");
    run_capture(0, WMAX'(3 * 5), 1, -1, -1, "p3x5");

    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    run_capture(0, WMAX'(16'(a) * 16'(b)), 1, 1 + 4, -1, "overrun");

    for (int k = 0; k < 6; k++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      run_capture(k % 2, WMAX'(16'(a) * 16'(b)), $urandom_range(0, 3), -1, -1,
                  $sformatf("rand%0d", k));
    end

    g = {1024'b0, {1024{1'b1}}};
    e = {1024'b0, {512{2'b10}}};
    p = g * e;
    run_capture(2, p, 1, -1, -1, "big");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_serial_collector.md
MULT_SERIAL_COLLECTOR -- requirements
Module: mult_serial_collector

Interface
REQ-001 Parameter N, default 1024: bit width of the serial (G) operand of the upstream multiplier.
REQ-002 Parameter M, default N: bit width of the parallel (e_init) operand of the upstream multiplier.
REQ-003 Parameter LAT, default 1: leading serial bits discarded after start, which is the upstream pipeline latency; range 0..7.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 rst  input  1: asynchronous, active-low reset.
REQ-006 start  input  1: one-cycle pulse, aligned with the first g_input bit driven upstream.
REQ-007 o_in  input  1: serial product bit from the multiplier's o output, LSB first.
REQ-008 out_ready  input  1: consumer accepts result when high together with valid.
REQ-009 busy  output  1: high while in SKIP or SHIFT.
REQ-010 valid  output  1: result holds a complete product.
REQ-011 result  output  N+M: assembled product, bit k = k-th kept serial bit.
REQ-012 overrun  output  1: sticky error flag; present only under COLLECT_OVERRUN_EN, otherwise tied 0.

Function
REQ-013 FSM states IDLE, SKIP, SHIFT, HOLD; encoding free.
REQ-014 IDLE + start -> SKIP if LAT>0, else SHIFT; counter cleared; result cleared to 0 the same edge.
REQ-015 SKIP: discard o_in for exactly LAT cycles, counting the start cycle as cycle 0; then -> SHIFT.
REQ-016 SHIFT: each cycle store o_in into result[cnt], cnt++; after the N+M-th bit (cnt = N+M-1 stored) -> HOLD.
REQ-017 Latency: valid rises LAT+N+M cycles after the edge that samples start.
REQ-018 HOLD: valid=1, result stable; valid && out_ready -> IDLE, valid low next cycle.
REQ-019 Counter width clog2(N+M+1); no wrap permitted; result never written outside SHIFT.
REQ-020 start outside IDLE is ignored; start in HOLD with out_ready=1 in the same cycle is ignored, so a new capture requires a fresh start in IDLE.
REQ-021 out_ready outside HOLD has no effect.
REQ-022 busy and valid are never high simultaneously.

Reset
REQ-023 rst=0 asynchronously forces IDLE, cnt=0, result=0, valid=0, busy=0, overrun=0.
REQ-024 Reset mid-SKIP or mid-SHIFT aborts the capture and discards partial bits; after release, the block waits for a new start.
REQ-025 Release of rst is synchronous to clk; the first start is honoured on the first edge after release.

Configuration
REQ-026 Macro COLLECT_OVERRUN_EN: when defined, overrun sets on start in SKIP, SHIFT or HOLD and clears only by reset.
REQ-027 Without COLLECT_OVERRUN_EN, no overrun logic is generated and the overrun port drives constant 0; all other behaviour is identical.

Verification
REQ-028 N=M=8, LAT=1, start, o_in = serial bits of 255*170, LSB first, after 1 skip -> valid at cycle 17, result=16'hA956.
REQ-029 Same stimulus, out_ready held 0 for 5 cycles after valid -> result stays 16'hA956 and valid stays 1; out_ready=1 -> IDLE next cycle.
REQ-030 N=M=8, LAT=0, o_in constant 1 -> result=16'hFFFF, valid at cycle 16.
REQ-031 rst low at cycle 6 of SHIFT, then new start with the product of 3*5 -> result=16'h000F, no stale bits.
REQ-032 With COLLECT_OVERRUN_EN, second start at cycle 4 of SHIFT -> overrun=1 and sticky; capture completes with the original value; without the macro -> overrun=0.
REQ-033 N=M=1024, LAT=1, G all ones, e_init={512{2'b10}} -> result equals G*e_init exactly.
